// File: rtl/rgb_led_pkg.sv
// Shared types for the RGB PWM blinker: the per-channel LED mode encoding.
package rgb_led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    OFF     = 2'd0,
    SOLID   = 2'd1,
    BLINK   = 2'd2,
    BREATHE = 2'd3
  } led_mode_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: holds mode, duty and the breathe ramp, derives the
// brightness level and compares it against the shared PWM counter.
// Optional square-law gamma stage enabled by defining RGB_PWM_GAMMA_EN.
module led_pwm_channel
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk48,
  input  logic                rst_n,
  input  logic                i_apply,
  input  led_mode_t           i_mode,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_step_tick,
  input  logic                i_blink_on,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic                UNLIT   = (ACTIVE_LOW != 0);

  led_mode_t             r_mode;
  logic [PWM_BITS-1:0]   r_duty;
  logic [PWM_BITS-1:0]   r_ramp;
  logic                  r_dir_down;
  logic                  r_led;
  logic                  w_ramp_restart;
  logic [2*PWM_BITS-1:0] w_breathe_prod;
  logic [PWM_BITS-1:0]   w_level;
  logic [PWM_BITS-1:0]   w_cmp_level;
  logic [PWM_BITS-1:0]   w_cmp_cnt;
  logic                  w_lit;

  // Only a mode change into BREATHE restarts the ramp; a rewrite keeps it.
  assign w_ramp_restart = i_apply && (i_mode == BREATHE) && (r_mode != BREATHE);

  // Channel configuration, updated only at the period boundary apply strobe.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= OFF;
      r_duty <= '0;
    end else if (i_apply) begin
      r_mode <= i_mode;
      r_duty <= i_duty;
    end
  end

  // Triangle ramp: holds one tick at each end, never wraps.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp     <= '0;
      r_dir_down <= 1'b0;
    end else if (w_ramp_restart) begin
      r_ramp     <= '0;
      r_dir_down <= 1'b0;
    end else if (i_step_tick) begin
      if (!r_dir_down) begin
        if (r_ramp == LVL_MAX) r_dir_down <= 1'b1;
        else                   r_ramp     <= r_ramp + 1'b1;
      end else begin
        if (r_ramp == '0) r_dir_down <= 1'b0;
        else              r_ramp     <= r_ramp - 1'b1;
      end
    end
  end

  assign w_breathe_prod = {{PWM_BITS{1'b0}}, r_ramp} * {{PWM_BITS{1'b0}}, r_duty};

  // Brightness level selected by mode.
  always_comb begin
    w_level = '0;
    case (r_mode)
      SOLID:   w_level = r_duty;
      BLINK:   w_level = i_blink_on ? r_duty : '0;
      BREATHE: w_level = PWM_BITS'(w_breathe_prod >> PWM_BITS);
      default: w_level = '0;
    endcase
  end

`ifdef RGB_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_gamma_prod;
  logic [PWM_BITS-1:0]   r_level_g;
  logic [PWM_BITS-1:0]   r_pwm_g;

  assign w_gamma_prod = {{PWM_BITS{1'b0}}, w_level} * {{PWM_BITS{1'b0}}, w_level};

  // Gamma stage; the counter is delayed with it so the period boundary stays aligned.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_level_g <= '0;
      r_pwm_g   <= '0;
    end else begin
      r_level_g <= PWM_BITS'(w_gamma_prod >> PWM_BITS);
      r_pwm_g   <= i_pwm_cnt;
    end
  end

  assign w_cmp_level = r_level_g;
  assign w_cmp_cnt   = r_pwm_g;
`else
  assign w_cmp_level = w_level;
  assign w_cmp_cnt   = i_pwm_cnt;
`endif

  assign w_lit = (w_cmp_cnt < w_cmp_level);

  // Registered pin drive with board polarity.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) r_led <= UNLIT;
    else        r_led <= w_lit ? ~UNLIT : UNLIT;
  end

  assign o_led = r_led;

endmodule

// File: rtl/rgb_pwm_blinker.sv
// Multi-channel LED PWM driver: shared PWM counter, step/blink timebase and
// a valid/ready config port whose writes land at a PWM period boundary.
// Define RGB_PWM_GAMMA_EN to add a registered square-law gamma per channel.
module rgb_pwm_blinker
  import rgb_led_pkg::*;
#(
  parameter  int CHANNELS    = 3,
  parameter  int PWM_BITS    = 8,
  parameter  int STEP_DIV    = 187500,
  parameter  int BLINK_STEPS = 128,
  parameter  int ACTIVE_LOW  = 1,
  localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk48,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] led
);

  localparam int STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int BLINK_W = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_STEPS - 1);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_on;
  logic                r_pending;
  logic [CHAN_W-1:0]   r_sh_chan;
  led_mode_t           r_sh_mode;
  logic [PWM_BITS-1:0] r_sh_duty;
  logic                w_pwm_max;
  logic                w_step_tick;
  logic                w_xfer;
  logic                w_apply;
  logic [CHAN_W-1:0]   w_ap_chan;
  led_mode_t           w_ap_mode;
  logic [PWM_BITS-1:0] w_ap_duty;

  assign w_pwm_max   = &r_pwm_cnt;
  assign w_step_tick = (r_step_cnt == STEP_LAST);

  // Free-running PWM counter, wraps naturally.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // Step divider producing a one-cycle tick every STEP_DIV clocks.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n)           r_step_cnt <= '0;
    else if (w_step_tick) r_step_cnt <= '0;
    else                  r_step_cnt <= r_step_cnt + 1'b1;
  end

  // Shared blink phase, toggled every BLINK_STEPS ticks.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_step_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // A write arriving in the boundary cycle bypasses the shadow and applies at once.
  assign cfg_ready = ~r_pending;
  assign w_xfer    = cfg_valid && ~r_pending;
  assign w_apply   = w_pwm_max && (r_pending || w_xfer);
  assign w_ap_chan = r_pending ? r_sh_chan : cfg_chan;
  assign w_ap_mode = r_pending ? r_sh_mode : led_mode_t'(cfg_mode);
  assign w_ap_duty = r_pending ? r_sh_duty : cfg_duty;

  // Shadow registers and pending flag for the config handshake.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_sh_chan <= '0;
      r_sh_mode <= OFF;
      r_sh_duty <= '0;
    end else begin
      if (w_apply)     r_pending <= 1'b0;
      else if (w_xfer) r_pending <= 1'b1;
      if (w_xfer) begin
        r_sh_chan <= cfg_chan;
        r_sh_mode <= led_mode_t'(cfg_mode);
        r_sh_duty <= cfg_duty;
      end
    end
  end

  // Out-of-range channel indices match no instance, so the write is dropped.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic w_chan_apply;
    assign w_chan_apply = w_apply && (w_ap_chan == CHAN_W'(gi));

    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk48       (clk48),
      .rst_n       (rst_n),
      .i_apply     (w_chan_apply),
      .i_mode      (w_ap_mode),
      .i_duty      (w_ap_duty),
      .i_step_tick (w_step_tick),
      .i_blink_on  (r_blink_on),
      .i_pwm_cnt   (r_pwm_cnt),
      .o_led       (led[gi])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_blinker.sv
// Directed bench for rgb_pwm_blinker (PWM_BITS=8, STEP_DIV=4, BLINK_STEPS=2).
// Config writes go into a scoreboard queue with their expected apply cycle;
// expected LED values are pushed one cycle ahead and popped against the pins.
module tb_rgb_pwm_blinker;

  localparam int SD = 4;
  localparam int BS = 2;

  logic       clk48     = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan  = '0;
  logic [1:0] cfg_mode  = '0;
  logic [7:0] cfg_duty  = '0;
  logic [2:0] led;

  rgb_pwm_blinker #(
    .CHANNELS    (3),
    .PWM_BITS    (8),
    .STEP_DIV    (SD),
    .BLINK_STEPS (BS),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mode  (cfg_mode),
    .cfg_duty  (cfg_duty),
    .led       (led)
  );

  always #10 clk48 = ~clk48;

  // Cycle index since reset release; equals the DUT pwm count modulo 256.
  int cyc = 0;
  always @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int chan;
    int mode;
    int duty;
    int start;
  } cfg_t;

  cfg_t       cfg_q[$];
  logic [2:0] led_q[$];
  int         m_mode[3];
  int         m_duty[3];
  int         m_bstart[3];
  int         lo_from = 1;
  int         lo_to   = 0;
  int         n_vec   = 0;
  int         n_err   = 0;

  function automatic int tri_val(int k);
    int m;
    m = k % 512;
    return (m <= 255) ? m : 511 - m;
  endfunction

  function automatic int level_of(int ch, int c);
    case (m_mode[ch])
      0:       return 0;
      1:       return m_duty[ch];
      2:       return (((c / (SD * BS)) % 2) == 0) ? m_duty[ch] : 0;
      default: return (tri_val(c / SD - m_bstart[ch] / SD) * m_duty[ch]) >> 8;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic install(input cfg_t e);
    if (e.chan < 3) begin
      if (e.mode == 3 && m_mode[e.chan] != 3) m_bstart[e.chan] = e.start;
      m_mode[e.chan] = e.mode;
      m_duty[e.chan] = e.duty;
    end
  endtask

  task automatic step();
    logic [2:0] exp_led;
    logic [2:0] popped;
    @(negedge clk48);
    while (cfg_q.size() > 0 && cfg_q[0].start == cyc) install(cfg_q.pop_front());
    if (led_q.size() > 0) begin
      popped = led_q.pop_front();
      check("led", {5'b0, led}, {5'b0, popped});
    end
    for (int ch = 0; ch < 3; ch++)
      exp_led[ch] = ((cyc % 256) < level_of(ch, cyc)) ? 1'b0 : 1'b1;
    led_q.push_back(exp_led);
    check("cfg_ready", {7'b0, cfg_ready}, {7'b0, !(cyc >= lo_from && cyc <= lo_to)});
  endtask

  task automatic send(input int chan, input int mode, input int duty);
    int   x;
    int   a;
    logic done;
    done      = 1'b0;
    cfg_valid = 1'b1;
    cfg_chan  = 2'(chan);
    cfg_mode  = 2'(mode);
    cfg_duty  = 8'(duty);
    for (int i = 0; i < 2000 && !done; i++) begin
      if (cfg_ready === 1'b1) begin
        x = cyc;
        a = x + (255 - (x % 256));
        cfg_q.push_back('{chan, mode, duty, a + 1});
        lo_from = x + 1;
        lo_to   = a;
        done    = 1'b1;
      end
      step();
    end
    cfg_valid = 1'b0;
    check("send_accepted", {7'b0, done}, 8'd1);
  endtask

  task automatic do_reset(input int hold);
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_q.delete();
    led_q.delete();
    for (int ch = 0; ch < 3; ch++) begin
      m_mode[ch]   = 0;
      m_duty[ch]   = 0;
      m_bstart[ch] = 0;
    end
    lo_from = 1;
    lo_to   = 0;
    repeat (hold) begin
      @(negedge clk48);
      check("rst_led", {5'b0, led}, 8'h07);
      check("rst_ready", {7'b0, cfg_ready}, 8'd1);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    repeat (1000) step();

    send(0, 1, 64);
    repeat (600) step();

    send(1, 2, 255);
    repeat (600) step();

    send(2, 3, 255);
    repeat (2300) step();

    send(0, 1, 200);
    send(0, 3, 128);
    repeat (600) step();

    send(2, 3, 100);
    repeat (400) step();

    send(3, 1, 200);
    repeat (400) step();

    for (int i = 0; i < 300 && (cyc % 256) != 255; i++) step();
    send(1, 1, 255);
    repeat (600) step();

    send(0, 1, 10);
    repeat (20) step();
    do_reset(2);
    repeat (600) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
